// File: rtl/fw_ram_arbiter_pkg.sv
// fw_ram_arbiter_pkg
//   Shared definitions for the firmware RAM arbiter: FSM state encoding,
//   RAM geometry, default clear pattern and the FW RAM window in the CPU
//   address map (used by the interconnect decode).
package fw_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'h0,
    ST_CLEAR  = 2'h1,
    ST_LOCKED = 2'h2
  } state_e;

  localparam int unsigned FW_RAM_WORDS        = 256;
  localparam logic [31:0] DEFAULT_CLEAR_VALUE = 32'h0000_0000;

  // Byte address window of the FW RAM in the CPU memory map.
  localparam logic [31:0] FW_RAM_FIRST = 32'hd000_0000;
  localparam logic [31:0] FW_RAM_LAST  = 32'hd000_03ff;

endpackage

// File: rtl/fw_ram_arbiter.sv
// fw_ram_arbiter
//   Owns the firmware RAM. In IDLE, CPU accesses pass straight through to
//   the RAM macro and complete one cycle later. A clear request waits for
//   any in-flight CPU access, then writes CLEAR_VALUE to every word (one
//   word per cycle), after which the RAM is locked: CPU accesses still
//   complete but reads return 0, writes are dropped and the RAM is never
//   selected again until reset.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   clear_req         single-cycle request to clear and lock the RAM
//   cpu_cs/we/address/write_data   CPU request (cs held until cpu_ready)
//   cpu_read_data     read data, valid while cpu_ready=1 (0 otherwise)
//   cpu_ready         one-cycle completion pulse
//   ram_cs/we/address/write_data   RAM macro controls
//   ram_read_data     RAM read data, valid the cycle after ram_cs
//   busy              clear pending or in progress
//   locked            clear finished; sticky until reset
module fw_ram_arbiter
  import fw_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter logic [31:0] CLEAR_VALUE = DEFAULT_CLEAR_VALUE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic                  cpu_cs,
  input  logic [3:0]            cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [31:0]           cpu_write_data,
  output logic [31:0]           cpu_read_data,
  output logic                  cpu_ready,
  output logic                  ram_cs,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_write_data,
  input  logic [31:0]           ram_read_data,
  output logic                  busy,
  output logic                  locked
);

  state_e                  state_q, state_d;
  logic                    clear_pending_q, clear_pending_d;
  logic                    ready_q, ready_d;
  logic [ADDR_WIDTH-1:0]   ctr_q, ctr_d;
  logic                    cpu_start;

  // A new CPU access may only start in IDLE, not on the cycle after one
  // started (cs is still held then), and not while a clear is waiting:
  // the clearer wins the arbitration on its entry cycle.
  assign cpu_start = (state_q == ST_IDLE) && cpu_cs && !ready_q && !clear_pending_q;

  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q;
    ready_d         = 1'b0;
    ctr_d           = ctr_q;
    unique case (state_q)
      ST_IDLE: begin
        ready_d = cpu_start;
        if (clear_pending_q && !ready_q) begin
          state_d         = ST_CLEAR;
          clear_pending_d = 1'b0;
        end else if (clear_req) begin
          clear_pending_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        ctr_d = ctr_q + ADDR_WIDTH'(1);
        if (ctr_q == '1) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        ready_d = cpu_cs && !ready_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      clear_pending_q <= 1'b0;
      ready_q         <= 1'b0;
      ctr_q           <= '0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      ready_q         <= ready_d;
      ctr_q           <= ctr_d;
    end
  end

  always_comb begin
    ram_cs         = 1'b0;
    ram_we         = '0;
    ram_address    = '0;
    ram_write_data = '0;
    if (state_q == ST_CLEAR) begin
      ram_cs         = 1'b1;
      ram_we         = '1;
      ram_address    = ctr_q;
      ram_write_data = CLEAR_VALUE;
    end else if (cpu_start) begin
      ram_cs         = 1'b1;
      ram_we         = cpu_we;
      ram_address    = cpu_address;
      ram_write_data = cpu_write_data;
    end
  end

  // ready_q in IDLE always follows a real RAM access (a clear cannot begin
  // while ready_q is set); in LOCKED it follows a dropped access, so the
  // RAM output must be masked there.
  assign cpu_ready     = ready_q;
  assign cpu_read_data = (ready_q && (state_q == ST_IDLE)) ? ram_read_data : '0;
  assign busy          = clear_pending_q || (state_q == ST_CLEAR);
  assign locked        = (state_q == ST_LOCKED);

endmodule
